dmem_sized: RTL and testbench

Parametrised data memory for the pipelined MIPS processor's MEM stage. It is the successor to the word-only data memory. It takes byte addresses and supports byte, halfword, word and (at 64-bit width) doubleword loads and stores. Stores use byte-lane enables; loads are sign- or zero-extended. After reset, the block clears its whole array in a self-timed init sequence. Reads are registered with one-cycle latency, so the MEM/WB boundary sees a stable, valid-qualified result.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_load_align.sv | 39 +++
 rtl/dmem_sized.sv | 151 +++++++++++++++
 tb/tb_dmem_sized.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory.
// Contents: access-size encodings, the init/ready state type, and a
// helper that turns a size code into a byte count.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic {INIT, READY} dmem_state_t;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane alignment: shifts the addressed bytes of a memory word down to
// bit 0 and sign- or zero-extends them above the access size.
// Ports:
//   word_i     full memory word
//   off_i      byte offset of the access inside the word (already aligned)
//   nbytes_i   access size in bytes (1..BYTES)
//   unsigned_i 1 = zero-extend, 0 = sign-extend
//   data_o     right-justified, extended result
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [OFF_W:0]    nbytes_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] sh;
  logic              sign;

  always_comb begin
    sh   = word_i >> {off_i, 3'b000};
    sign = 1'b0;
    // sign bit is the top bit of the last byte that belongs to the access
    for (int b = 0; b < BYTES; b++)
      if (b == int'(nbytes_i) - 1) sign = sh[b*8+7];
    if (unsigned_i) sign = 1'b0;
    data_o = sh;
    // full-width accesses have no byte above the size, so nothing is filled
    for (int b = 0; b < BYTES; b++)
      if (b >= int'(nbytes_i)) data_o[b*8 +: 8] = {8{sign}};
  end

endmodule

// File: rtl/dmem_sized.sv
// Sized data memory for the MEM stage: byte addresses, byte/half/word/dword
// loads and stores, registered one-cycle read, self-clearing after reset.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (adds the misalign port and
// traps misaligned/illegal accesses instead of force-aligning them).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_read        load request
//   mem_write       store request
//   size            00 byte, 01 half, 10 word, 11 dword
//   load_unsigned   1 = zero-extend load
//   address         byte address
//   write_data      store data, right-justified
//   read_data       registered load result (holds when no load)
//   read_valid      one-cycle pulse qualifying read_data
//   busy            array clear in progress, requests dropped
//   misalign        misaligned access flag (trap build only)
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  dmem_state_t       state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off, lmask, off_al;
  logic [OFF_W:0]    nb;
  logic [1:0]        sz_eff;
  logic              illegal, mis, acc, rd_acc, wr_acc;
  logic [DATA_W-1:0] rd_word, ld_data, wsh, wr_word;

  // upper address bits only wrap the index; fold them into a sink
  logic unused_addr;
  assign unused_addr = ^address;

  assign idx = address[OFF_W +: IDX_W];
  assign off = address[OFF_W-1:0];

  // datapath always sees a legal size; the trap build flags illegal ones
  assign illegal = (DATA_W == 32) && (size == SZ_DWORD);
  assign sz_eff  = illegal ? SZ_WORD : size;
  assign nb      = (OFF_W+1)'(size_bytes(sz_eff));
  assign lmask   = OFF_W'(nb - (OFF_W+1)'(1));
  assign off_al  = off & ~lmask;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = illegal | (|(off & lmask));
`else
  assign mis = 1'b0;
`endif

  assign acc    = (state_q == READY) && !rst;
  assign rd_acc = acc && mem_read;
  assign wr_acc = acc && mem_write && !mis;

  // read-before-write: the load and the merge both use pre-store contents
  assign rd_word = mem_q[idx];

  dmem_load_align #(.DATA_W(DATA_W)) u_align (
    .word_i     (rd_word),
    .off_i      (off_al),
    .nbytes_i   (nb),
    .unsigned_i (load_unsigned),
    .data_o     (ld_data)
  );

  always_comb begin
    wsh     = write_data << {off_al, 3'b000};
    wr_word = rd_word;
    for (int b = 0; b < BYTES; b++)
      if (b >= int'(off_al) && b < int'(off_al) + int'(nb))
        wr_word[b*8 +: 8] = wsh[b*8 +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = READY;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mis ? '0 : ld_data;
  end

  // array has no reset; it is cleared by the INIT sweep instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) mem_q[cnt_q] <= '0;
      else if (wr_acc)     mem_q[idx]   <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd_acc;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= acc && (mem_read || mem_write) && mis;
  end
  assign misalign = mis_q;
`endif

  assign read_data  = rdata_q;
  assign read_valid = rvalid_q;
  assign busy       = (state_q == INIT);

endmodule

// File: tb/tb_dmem_sized.sv
module tb_dmem_sized;

  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        read_valid, busy;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_sized #(.DATA_W(32), .DEPTH(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .address(address),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
    .busy(busy)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  // ---------------- reference model: flat 64-byte little-endian memory ----
  logic [7:0]  mb [64];
  logic [31:0] m_rdata = '0;
  bit          m_rvalid = 0, m_mis = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b11) ? 4 : (1 << sz);
  endfunction

  function automatic bit mdl_mis(input logic [1:0] sz, input logic [31:0] a);
    if (!TRAP) return 0;
    return (sz == 2'b11) || ((a % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    int n = nbytes(sz);
    int base = int'(a % 64);
    logic [31:0] v = '0;
    if (mdl_mis(sz, a)) return '0;
    base = base - (base % n);
    for (int i = 0; i < n; i++) v |= 32'(mb[base+i]) << (8*i);
    if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
    return v;
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = nbytes(sz);
    int base = int'(a % 64);
    if (mdl_mis(sz, a)) return;
    base = base - (base % n);
    for (int i = 0; i < n; i++) mb[base+i] = wd[8*i +: 8];
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 64; i++) mb[i] = '0;
  endtask

  // drive one request at a negedge, return at the following negedge
  task automatic step(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns;
    address = a; write_data = wd;
    @(negedge clk);
    mem_read = 0; mem_write = 0;
    m_rvalid = rd;
    m_mis    = (rd || wr) && mdl_mis(sz, a);
    if (rd) m_rdata = mdl_load(sz, uns, a);
    if (wr) mdl_store(sz, a, wd);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit rd; bit wr; logic [1:0] sz; bit uns;
    logic [31:0] addr; logic [31:0] wd;
    bit ev; logic [31:0] ed; bit em;
  } vec_t;
  vec_t tv[$];

  localparam logic [31:0] EXP_LH11  = TRAP ? 32'h0000_0000 : 32'hFFFF_AA21;
  localparam logic [31:0] EXP_LW10B = TRAP ? 32'hBEEF_AA21 : 32'hFFFF_FFFF;

  initial begin
    int n;
    bit saw_rv;
    // rd wr sz uns addr wd ev ed em
    tv.push_back('{1,0,2'b10,0,32'h3C,32'h0,         1,32'h0000_0000,0});
    tv.push_back('{0,1,2'b10,0,32'h10,32'h8765_4321, 0,32'h0000_0000,0});
    tv.push_back('{1,0,2'b00,0,32'h13,32'h0,         1,32'hFFFF_FF87,0});
    tv.push_back('{1,0,2'b00,1,32'h13,32'h0,         1,32'h0000_0087,0});
    tv.push_back('{1,0,2'b01,0,32'h12,32'h0,         1,32'hFFFF_8765,0});
    tv.push_back('{1,0,2'b01,1,32'h10,32'h0,         1,32'h0000_4321,0});
    tv.push_back('{0,1,2'b00,0,32'h11,32'hAA,        0,32'h0000_4321,0});
    tv.push_back('{1,0,2'b10,0,32'h10,32'h0,         1,32'h8765_AA21,0});
    tv.push_back('{0,1,2'b01,0,32'h12,32'hBEEF,      0,32'h8765_AA21,0});
    tv.push_back('{1,0,2'b10,0,32'h10,32'h0,         1,32'hBEEF_AA21,0});
    tv.push_back('{0,1,2'b10,0,32'h20,32'h1111_1111, 0,32'hBEEF_AA21,0});
    tv.push_back('{1,1,2'b10,0,32'h20,32'h2222_2222, 1,32'h1111_1111,0});
    tv.push_back('{1,0,2'b10,0,32'h20,32'h0,         1,32'h2222_2222,0});
    tv.push_back('{0,1,2'b10,0,32'h40,32'hCAFE_F00D, 0,32'h2222_2222,0});
    tv.push_back('{1,0,2'b10,0,32'h00,32'h0,         1,32'hCAFE_F00D,0});
    tv.push_back('{0,0,2'b10,0,32'h00,32'h0,         0,32'hCAFE_F00D,0});
    tv.push_back('{0,0,2'b10,0,32'h00,32'h0,         0,32'hCAFE_F00D,0});
    tv.push_back('{0,0,2'b10,0,32'h00,32'h0,         0,32'hCAFE_F00D,0});
    tv.push_back('{1,0,2'b01,0,32'h11,32'h0,         1,EXP_LH11,TRAP});
    tv.push_back('{0,1,2'b10,0,32'h12,32'hFFFF_FFFF, 0,EXP_LH11,TRAP});
    tv.push_back('{1,0,2'b10,0,32'h10,32'h0,         1,EXP_LW10B,0});

    // reset held 3 cycles
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset read_data", read_data, 32'h0);
    chk("reset read_valid", 32'(read_valid), 32'h0);
    chk("reset busy", 32'(busy), 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("reset misalign", 32'(misalign), 32'h0);
`endif
    rst = 0;
    count_busy(n);
    chk("init busy cycles", 32'(n), 32'd16);

    // restart mid-init at cycle 8; requests during init must be dropped
    rst = 1; @(negedge clk); rst = 0;
    repeat (8) @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    mem_read = 1; address = 32'h0; size = 2'b10;
    saw_rv = 0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      if (read_valid) saw_rv = 1;
    end
    mem_read = 0;
    chk("restart busy cycles", 32'(n), 32'd16);
    chk("no response during init", 32'(saw_rv), 32'h0);
    mdl_clear();
    m_rdata = '0;

    // directed table
    foreach (tv[i]) begin
      step(tv[i].rd, tv[i].wr, tv[i].sz, tv[i].uns, tv[i].addr, tv[i].wd);
      chk($sformatf("vec%0d read_valid", i), 32'(read_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d read_data", i), read_data, tv[i].ed);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk($sformatf("vec%0d misalign", i), 32'(misalign), 32'(tv[i].em));
`endif
    end

    // randomized traffic against the byte-array model
    for (int k = 0; k < 400; k++) begin
      bit rd, wr, uns;
      logic [1:0] sz;
      logic [31:0] a, wd;
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      wd  = $urandom;
      step(rd, wr, sz, uns, a, wd);
      chk($sformatf("rnd%0d read_valid", k), 32'(read_valid), 32'(m_rvalid));
      chk($sformatf("rnd%0d read_data", k), read_data, m_rdata);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk($sformatf("rnd%0d misalign", k), 32'(misalign), 32'(m_mis));
`endif
    end

    // reset coinciding with a load cancels its response
    mem_read = 1; size = 2'b10; address = 32'h10; rst = 1;
    @(negedge clk);
    mem_read = 0; rst = 0;
    chk("rst cancels read_valid", 32'(read_valid), 32'h0);
    chk("rst clears read_data", read_data, 32'h0);
    chk("rst sets busy", 32'(busy), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
